// File: rtl/aqp_spi_cmdproc_if.sv
// aqp_spi_cmdproc_if: framing, byte stream, transmit and memory bus signals
// of the SPI command processor. "master" is the command processor side,
// "slave" is the SPI slave plus memory side.
interface aqp_spi_cmdproc_if #(
  parameter int ADDR_W = 16
);
  logic              msg_start;
  logic              msg_end;
  logic [7:0]        rxdata;
  logic              rxdata_valid;
  logic [7:0]        txdata;
  logic              txdata_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wrdata;
  logic              bus_wr;
  logic              bus_rd;
  logic [7:0]        bus_rddata;
  logic              bus_ack;
  logic              busy;

  modport master (
    input  msg_start, msg_end, rxdata, rxdata_valid, txdata_ack, bus_rddata, bus_ack,
    output txdata, bus_addr, bus_wrdata, bus_wr, bus_rd, busy
  );

  modport slave (
    output msg_start, msg_end, rxdata, rxdata_valid, txdata_ack, bus_rddata, bus_ack,
    input  txdata, bus_addr, bus_wrdata, bus_wr, bus_rd, busy
  );
endinterface

// File: rtl/aqp_spi_cmdproc.sv
// aqp_spi_cmdproc: parses SSEL-framed SPI messages into byte-wide memory bus
// reads/writes with auto-incrementing address, and returns read data or a
// status byte on the SPI transmit path.
// Optional bus timeout: define AQP_SPICMD_BUSTIMEOUT_EN.
// ADDR_W is at most 16 (address arrives as two bytes).
//
// state   | meaning
// IDLE    | no message framed
// CMD     | waiting for the command byte
// ADDR_LO | waiting for address low byte
// ADDR_HI | waiting for address high byte
// WDATA   | each received byte becomes a bus write
// RDATA   | each txdata_ack fetches the next byte
// STAT    | status byte presented; flags clear when it is loaded
// DISCARD | ignore bytes until msg_end
module aqp_spi_cmdproc #(
  parameter int ADDR_W = 16
) (
  input logic               clk,
  input logic               reset_n,
  aqp_spi_cmdproc_if.master cp
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_LO, S_ADDR_HI, S_WDATA, S_RDATA, S_STAT, S_DISCARD
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nxt;
  logic              mode_wr, mode_wr_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        addr_lo, addr_lo_nxt;
  logic [15:0]       addr_full;
  logic [7:0]        tx_q;
  logic              overrun, err_cmd, timeout;
  logic [7:0]        status;

  logic              bus_wr_q, bus_rd_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [7:0]        bus_wrdata_q;
  // one-deep hold for a request accepted while the bus is still occupied
  logic              q_valid, q_wr;
  logic [ADDR_W-1:0] q_addr;
  logic [7:0]        q_data;

  logic              req_active, req_done, req_pending, to_expire;
  logic              nr_valid, nr_wr;
  logic [ADDR_W-1:0] nr_addr;
  logic [7:0]        nr_data;
  logic              set_ovr, set_err, clr_flags, load_stat, clear_tx;

  assign addr_full   = {cp.rxdata, addr_lo};
  assign status      = {5'b0, timeout, err_cmd, overrun};
  assign req_active  = bus_wr_q | bus_rd_q;
  assign req_done    = req_active & (cp.bus_ack | to_expire);
  assign req_pending = (req_active & ~req_done) | q_valid;

  assign cp.txdata     = (state == S_RDATA || state == S_STAT) ? tx_q : 8'hFF;
  assign cp.bus_wr     = bus_wr_q;
  assign cp.bus_rd     = bus_rd_q;
  assign cp.bus_addr   = bus_addr_q;
  assign cp.bus_wrdata = bus_wrdata_q;
  assign cp.busy       = (state != S_IDLE) | req_active | q_valid;

  // Parser next state, address tracking and new bus request generation.
  always_comb begin
    state_nxt   = state;
    mode_wr_nxt = mode_wr;
    addr_nxt    = addr;
    addr_lo_nxt = addr_lo;
    nr_valid    = 1'b0;
    nr_wr       = 1'b0;
    nr_addr     = addr;
    nr_data     = cp.rxdata;
    set_ovr     = 1'b0;
    set_err     = 1'b0;
    clr_flags   = 1'b0;
    load_stat   = 1'b0;
    clear_tx    = 1'b0;
    if (cp.msg_start) begin
      state_nxt   = S_CMD;
      mode_wr_nxt = 1'b0;
    end else if (cp.msg_end) begin
      state_nxt   = S_IDLE;
      mode_wr_nxt = 1'b0;
    end else begin
      case (state)
        S_CMD: if (cp.rxdata_valid) begin
          case (cp.rxdata)
            8'h01:   begin state_nxt = S_ADDR_LO; mode_wr_nxt = 1'b1; end
            8'h02:   begin state_nxt = S_ADDR_LO; mode_wr_nxt = 1'b0; end
            8'h03:   begin state_nxt = S_STAT;    load_stat   = 1'b1; end
            default: begin state_nxt = S_DISCARD; set_err     = 1'b1; end
          endcase
        end
        S_ADDR_LO: if (cp.rxdata_valid) begin
          addr_lo_nxt = cp.rxdata;
          state_nxt   = S_ADDR_HI;
        end
        S_ADDR_HI: if (cp.rxdata_valid) begin
          addr_nxt = addr_full[ADDR_W-1:0];
          if (mode_wr) begin
            state_nxt = S_WDATA;
          end else begin
            state_nxt = S_RDATA;
            clear_tx  = 1'b1;
            if (q_valid) begin
              set_ovr = 1'b1;
            end else begin
              nr_valid = 1'b1;
              nr_addr  = addr_full[ADDR_W-1:0];
            end
          end
        end
        S_WDATA: if (cp.rxdata_valid) begin
          if (req_pending) begin
            set_ovr = 1'b1;
          end else begin
            nr_valid = 1'b1;
            nr_wr    = 1'b1;
            addr_nxt = addr + ADDR_ONE;
          end
        end
        S_RDATA: if (cp.txdata_ack) begin
          if (req_pending) begin
            set_ovr = 1'b1;
          end else begin
            nr_valid = 1'b1;
            nr_addr  = addr + ADDR_ONE;
            addr_nxt = addr + ADDR_ONE;
          end
        end
        S_STAT: if (cp.txdata_ack) begin
          clr_flags = 1'b1;
          state_nxt = S_DISCARD;
        end
        default: ;
      endcase
    end
  end

  // Parser registers, sticky flags and transmit byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      mode_wr <= 1'b0;
      addr    <= '0;
      addr_lo <= 8'h00;
      overrun <= 1'b0;
      err_cmd <= 1'b0;
      tx_q    <= 8'hFF;
    end else begin
      state   <= state_nxt;
      mode_wr <= mode_wr_nxt;
      addr    <= addr_nxt;
      addr_lo <= addr_lo_nxt;
      if (clr_flags) begin
        overrun <= 1'b0;
        err_cmd <= 1'b0;
      end else begin
        if (set_ovr) overrun <= 1'b1;
        if (set_err) err_cmd <= 1'b1;
      end
      // read data only lands in RDATA so a late read cannot clobber a status byte
      if (load_stat)
        tx_q <= status;
      else if (clear_tx)
        tx_q <= 8'hFF;
      else if (req_done && bus_rd_q && state == S_RDATA)
        tx_q <= cp.bus_ack ? cp.bus_rddata : 8'hFF;
    end
  end

  // Bus request: hold until ack, always leave a gap cycle before the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_wr_q     <= 1'b0;
      bus_rd_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wrdata_q <= 8'h00;
      q_valid      <= 1'b0;
      q_wr         <= 1'b0;
      q_addr       <= '0;
      q_data       <= 8'h00;
    end else begin
      if (req_done) begin
        bus_wr_q <= 1'b0;
        bus_rd_q <= 1'b0;
      end
      if (nr_valid) begin
        if (req_active) begin
          q_valid <= 1'b1;
          q_wr    <= nr_wr;
          q_addr  <= nr_addr;
          q_data  <= nr_data;
        end else begin
          bus_wr_q   <= nr_wr;
          bus_rd_q   <= ~nr_wr;
          bus_addr_q <= nr_addr;
          if (nr_wr) bus_wrdata_q <= nr_data;
        end
      end else if (q_valid && !req_active) begin
        q_valid    <= 1'b0;
        bus_wr_q   <= q_wr;
        bus_rd_q   <= ~q_wr;
        bus_addr_q <= q_addr;
        if (q_wr) bus_wrdata_q <= q_data;
      end
    end
  end

`ifdef AQP_SPICMD_BUSTIMEOUT_EN
  logic [7:0] to_cnt;

  assign to_expire = req_active & (to_cnt == 8'd0);

  // Down-counter: expires in the 255th cycle of an unacknowledged request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt  <= 8'd254;
      timeout <= 1'b0;
    end else begin
      if (!req_active)
        to_cnt <= 8'd254;
      else if (to_cnt != 8'd0)
        to_cnt <= to_cnt - 8'd1;
      if (clr_flags)
        timeout <= 1'b0;
      else if (to_expire && !cp.bus_ack)
        timeout <= 1'b1;
    end
  end
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
